axis_keep_downsizer: RTL and testbench

Next-generation AXI-Stream width downsizer: splits each wide slave beat of DATA_RATIO lanes into narrow master beats of one lane each.
- Adds lane-granular tkeep: null lanes are skipped, never emitted.
- Adds tuser passthrough and a selectable lane order.
- Runs bubble-free, so back-to-back wide beats sustain 1 narrow beat/cycle.
- Sits between wide datapath blocks and narrow-port consumers, e.g. a CDC FIFO write side.

---
 rtl/axis_pkg.sv | 22 ++
 rtl/axis_lane_prio_enc.sv | 33 +++
 rtl/axis_keep_downsizer.sv | 95 +++++++++
 tb/tb_axis_keep_downsizer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared helpers for the AXI-Stream width converters: lane-mask arithmetic,
// lane slicing and the converter occupancy state.
package axis_pkg;

  localparam int MAX_LANES = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // True when exactly one lane bit is set; callers zero-extend their mask to MAX_LANES.
  function automatic logic onehot_count_is_one(input logic [MAX_LANES-1:0] mask);
    return (mask != '0) && ((mask & (mask - MAX_LANES'(1))) == '0);
  endfunction

  // Bit offset of a lane inside a wide word.
  function automatic int lane_base(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/axis_lane_prio_enc.sv
// Picks the next lane to emit from a lane mask: lowest set bit when LSB_FIRST,
// highest otherwise. With an empty mask the index parks on the first lane of that order.
module axis_lane_prio_enc #(
  parameter int DATA_RATIO = 8,
  parameter bit LSB_FIRST  = 1'b1,
  localparam int IDX_W     = $clog2(DATA_RATIO)
) (
  input  logic [DATA_RATIO-1:0] mask,
  output logic [IDX_W-1:0]      index,
  output logic                  found
);

  always_comb begin
    index = LSB_FIRST ? '0 : IDX_W'(DATA_RATIO - 1);
    found = 1'b0;
    if (LSB_FIRST) begin
      for (int i = DATA_RATIO - 1; i >= 0; i--) begin
        if (mask[i]) begin
          index = IDX_W'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < DATA_RATIO; i++) begin
        if (mask[i]) begin
          index = IDX_W'(i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axis_keep_downsizer.sv
// AXI-Stream downsizer: one wide beat of DATA_RATIO lanes becomes one narrow beat
// per kept lane, with a single hold register and a load-through path for zero bubbles.
module axis_keep_downsizer
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int DATA_RATIO    = 8,
  parameter int USER_WIDTH    = 1,
  parameter bit LSB_FIRST     = 1'b1,
  localparam int S_DATA_WIDTH = DATA_RATIO * DATA_WIDTH
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [DATA_RATIO-1:0]   s_axis_tkeep,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tkeep,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready
);

  localparam int IDX_W = $clog2(DATA_RATIO);

  // Handshakes: a beat moves on a port at a rising edge where its valid and ready are both high.
  typedef struct packed {
    logic [S_DATA_WIDTH-1:0] data;
    logic [DATA_RATIO-1:0]   mask;
    logic [USER_WIDTH-1:0]   user;
    logic                    last;
    logic                    nullterm;
  } hold_t;

  hold_t                 hold_q;
  state_t                state;
  logic [IDX_W-1:0]      lane_idx;
  logic                  lane_found;
  logic [DATA_RATIO-1:0] lane_bit;
  logic                  final_beat;
  logic                  m_hs;
  logic                  s_hs;
  logic                  s_load;

  axis_lane_prio_enc #(
    .DATA_RATIO (DATA_RATIO),
    .LSB_FIRST  (LSB_FIRST)
  ) u_prio_enc (
    .mask  (hold_q.mask),
    .index (lane_idx),
    .found (lane_found)
  );

  assign state      = (lane_found || hold_q.nullterm) ? ST_BUSY : ST_IDLE;
  assign final_beat = hold_q.nullterm || onehot_count_is_one(MAX_LANES'(hold_q.mask));
  assign lane_bit   = {{(DATA_RATIO-1){1'b0}}, 1'b1} << lane_idx;

  assign m_axis_tvalid = (state == ST_BUSY);
  assign m_axis_tdata  = hold_q.data[lane_base(int'(lane_idx), DATA_WIDTH) +: DATA_WIDTH];
  assign m_axis_tkeep  = ~hold_q.nullterm;
  assign m_axis_tuser  = hold_q.user;
  assign m_axis_tlast  = hold_q.last && final_beat;

  assign m_hs          = m_axis_tvalid && m_axis_tready;
  // Load-through: the next wide beat enters on the edge the final narrow beat leaves.
  assign s_axis_tready = (state == ST_IDLE) || (m_hs && final_beat);
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  // A null beat without tlast carries nothing and is swallowed.
  assign s_load        = s_hs && ((s_axis_tkeep != '0) || s_axis_tlast);

  always_ff @(posedge aclk) begin
    if (areset) begin
      hold_q.mask     <= '0;
      hold_q.nullterm <= 1'b0;
      hold_q.last     <= 1'b0;
    end else begin
      if (m_hs) begin
        hold_q.mask     <= hold_q.mask & ~lane_bit;
        hold_q.nullterm <= 1'b0;
      end
      if (s_load) begin
        hold_q.data     <= s_axis_tdata;
        hold_q.user     <= s_axis_tuser;
        hold_q.last     <= s_axis_tlast;
        hold_q.mask     <= s_axis_tkeep;
        hold_q.nullterm <= (s_axis_tkeep == '0);
      end
    end
  end

endmodule

// File: tb/tb_axis_keep_downsizer.sv
// Bench for axis_keep_downsizer: an LSB-first and an MSB-first instance share the
// slave stimulus; each has its own expected-beat queue filled by a reference model.
module tb_axis_keep_downsizer;

  localparam int DW = 8;
  localparam int DR = 8;
  localparam int UW = 1;
  localparam int SW = DW * DR;
  localparam int BW = DW + 3;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  logic [SW-1:0] s_tdata = '0;
  logic [DR-1:0] s_tkeep = '0;
  logic [UW-1:0] s_tuser = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          m_tready = 1'b1;

  logic          s_ready0, s_ready1;
  logic [DW-1:0] m_data0, m_data1;
  logic          m_keep0, m_keep1;
  logic [UW-1:0] m_user0, m_user1;
  logic          m_valid0, m_valid1;
  logic          m_last0, m_last1;

  axis_keep_downsizer #(.DATA_WIDTH(DW), .DATA_RATIO(DR), .USER_WIDTH(UW), .LSB_FIRST(1'b1)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_ready0),
    .m_axis_tdata(m_data0), .m_axis_tkeep(m_keep0), .m_axis_tuser(m_user0),
    .m_axis_tvalid(m_valid0), .m_axis_tlast(m_last0), .m_axis_tready(m_tready)
  );

  axis_keep_downsizer #(.DATA_WIDTH(DW), .DATA_RATIO(DR), .USER_WIDTH(UW), .LSB_FIRST(1'b0)) dut_msb (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_ready1),
    .m_axis_tdata(m_data1), .m_axis_tkeep(m_keep1), .m_axis_tuser(m_user1),
    .m_axis_tvalid(m_valid1), .m_axis_tlast(m_last1), .m_axis_tready(m_tready)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [BW-1:0] exp_q0[$];
  logic [BW-1:0] exp_q1[$];
  int beats0 = 0;
  int beats1 = 0;
  int ready_mode = 0;  // 0: high, 1: pattern 1,0,0, 2: random
  int pat_cnt = 0;

  logic [BW-1:0] act0, act1, hold0, hold1;
  logic stall0 = 1'b0;
  logic stall1 = 1'b0;
  assign act0 = {m_last0, m_keep0, m_user0, m_data0};
  assign act1 = {m_last1, m_keep1, m_user1, m_data1};

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  // Reference model: expected narrow beats of one accepted wide beat, for both orders.
  task automatic push_expected(input logic [SW-1:0] d, input logic [DR-1:0] k,
                               input logic [UW-1:0] u, input logic l);
    int n;
    int seen;
    n = $countones(k);
    if (k == '0) begin
      if (l) begin
        exp_q0.push_back({1'b1, 1'b0, u, d[DW-1:0]});
        exp_q1.push_back({1'b1, 1'b0, u, d[SW-1 -: DW]});
      end
    end else begin
      seen = 0;
      for (int i = 0; i < DR; i++) begin
        if (k[i]) begin
          seen++;
          exp_q0.push_back({l && (seen == n), 1'b1, u, d[i*DW +: DW]});
        end
      end
      seen = 0;
      for (int i = DR - 1; i >= 0; i--) begin
        if (k[i]) begin
          seen++;
          exp_q1.push_back({l && (seen == n), 1'b1, u, d[i*DW +: DW]});
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Call at posedge+1; returns at posedge+1 right after the beat was accepted.
  task automatic send_beat(input logic [SW-1:0] d, input logic [DR-1:0] k,
                           input logic [UW-1:0] u, input logic l);
    int t;
    t = 0;
    s_tdata = d; s_tkeep = k; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    forever begin
      @(negedge aclk);
      if (s_ready0) break;
      t++;
      if (t > 300) begin
        n_cmp++; n_fail++;
        $display("FAIL send_timeout: s_axis_tready stayed 0 for %0d cycles, expected 1", t);
        break;
      end
    end
    if (t <= 300) push_expected(d, k, u, l);
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && t < 300) begin
      @(negedge aclk);
      t++;
    end
    n_cmp++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain_%s: %0d/%0d beats outstanding, expected 0/0", name, exp_q0.size(), exp_q1.size());
    end
    @(negedge aclk);
    check({name, "_idle_lsb"}, BW'(m_valid0), BW'(0));
    check({name, "_idle_msb"}, BW'(m_valid1), BW'(0));
    next_cycle();
  endtask

  // ---------------- master ready driver ----------------
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      case (ready_mode)
        0: m_tready = 1'b1;
        1: begin m_tready = (pat_cnt % 3 == 0); pat_cnt++; end
        2: m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b1;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge aclk);
      if (areset) begin
        stall0 = 1'b0;
        stall1 = 1'b0;
      end else begin
        if (m_valid0 && stall0) check("stable_lsb", act0, hold0);
        if (m_valid1 && stall1) check("stable_msb", act1, hold1);
        if (m_valid0 && m_tready) begin
          beats0++;
          if (exp_q0.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL beat_lsb: got unexpected %h, expected no beat", act0);
          end else check("beat_lsb", act0, exp_q0.pop_front());
        end
        if (m_valid1 && m_tready) begin
          beats1++;
          if (exp_q1.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL beat_msb: got unexpected %h, expected no beat", act1);
          end else check("beat_msb", act1, exp_q1.pop_front());
        end
        stall0 = m_valid0 && !m_tready;
        stall1 = m_valid1 && !m_tready;
        hold0 = act0;
        hold1 = act1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [SW-1:0] data;
    logic [DR-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
    int            beats;
  } vec_t;

  vec_t vecs[8];
  localparam logic [SW-1:0] RAMP = 64'h0706050403020100;

  initial begin
    vecs[0] = '{RAMP,                  8'hFF, 1'b0, 1'b1, 8};
    vecs[1] = '{RAMP,                  8'hA5, 1'b0, 1'b1, 4};
    vecs[2] = '{64'h1122334455667788, 8'h81, 1'b1, 1'b0, 2};
    vecs[3] = '{64'hDEADBEEFCAFEF00D, 8'h3C, 1'b1, 1'b1, 4};
    vecs[4] = '{64'h0123456789ABCDEF, 8'h01, 1'b0, 1'b1, 1};
    vecs[5] = '{64'hFEDCBA9876543210, 8'h80, 1'b1, 1'b1, 1};
    vecs[6] = '{64'hA1B2C3D4E5F60718, 8'h00, 1'b0, 1'b1, 1};
    vecs[7] = '{64'h5A5A5A5A5A5A5A5A, 8'h00, 1'b1, 1'b0, 0};

    // reset state
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    check("rst_valid_lsb", BW'(m_valid0), BW'(0));
    check("rst_valid_msb", BW'(m_valid1), BW'(0));
    check("rst_ready_lsb", BW'(s_ready0), BW'(1));
    check("rst_ready_msb", BW'(s_ready1), BW'(1));
    next_cycle();

    // full lanes: s_ready low for 7 middle cycles, high as lane 07 leaves
    send_beat(RAMP, 8'hFF, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge aclk);
      check("full_valid", BW'(m_valid0), BW'(1));
      check("full_sready_lsb", BW'(s_ready0), BW'(k == 7));
      check("full_sready_msb", BW'(s_ready1), BW'(k == 7));
    end
    drain("full");

    // back-to-back: 16 valid cycles, second beat loads as lane 07 leaves
    send_beat(RAMP, 8'hFF, 1'b0, 1'b0);
    fork
      send_beat(64'h8F8E8D8C8B8A8988, 8'hFF, 1'b1, 1'b1);
      for (int k = 0; k < 16; k++) begin
        @(negedge aclk);
        check("b2b_valid", BW'(m_valid0), BW'(1));
        check("b2b_sready", BW'(s_ready0), BW'(k == 7 || k == 15));
      end
    join
    drain("b2b");

    // null non-last beat is swallowed
    send_beat(64'h1111111111111111, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      check("nulldrop_valid", BW'(m_valid0), BW'(0));
      check("nulldrop_sready", BW'(s_ready0), BW'(1));
    end
    next_cycle();

    // table, ready held high
    for (int v = 0; v < 8; v++) begin
      beats0 = 0;
      beats1 = 0;
      send_beat(vecs[v].data, vecs[v].keep, vecs[v].user, vecs[v].last);
      drain("vec");
      check("vec_count_lsb", BW'(beats0), BW'(vecs[v].beats));
      check("vec_count_msb", BW'(beats1), BW'(vecs[v].beats));
    end

    // reset after 3 of 8 lanes
    send_beat(RAMP, 8'hFF, 1'b1, 1'b1);
    repeat (3) @(negedge aclk);
    @(posedge aclk);
    #1 areset = 1'b1;
    next_cycle();
    areset = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    @(negedge aclk);
    check("midrst_valid", BW'(m_valid0), BW'(0));
    check("midrst_sready", BW'(s_ready0), BW'(1));
    check("midrst_valid_msb", BW'(m_valid1), BW'(0));
    next_cycle();
    send_beat(64'h4746454443424140, 8'hFF, 1'b0, 1'b1);
    drain("midrst");

    // backpressure pattern 1,0,0
    pat_cnt = 0;
    ready_mode = 1;
    send_beat(RAMP, 8'h0F, 1'b1, 1'b1);
    drain("bp");
    send_beat(RAMP, 8'hA5, 1'b1, 1'b0);
    send_beat(RAMP, 8'h00, 1'b0, 1'b1);
    drain("bp_null");

    // table and random beats under random ready
    ready_mode = 2;
    for (int v = 0; v < 8; v++) begin
      beats0 = 0;
      beats1 = 0;
      send_beat(vecs[v].data, vecs[v].keep, vecs[v].user, vecs[v].last);
      drain("rvec");
      check("rvec_count_lsb", BW'(beats0), BW'(vecs[v].beats));
      check("rvec_count_msb", BW'(beats1), BW'(vecs[v].beats));
    end
    for (int r = 0; r < 24; r++) begin
      send_beat({$urandom(), $urandom()}, DR'($urandom_range(0, 255)),
                UW'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain("rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
